// File: rtl/and2.sv
// Two-input AND gate cell: combinational NAND+inverter output plus a clocked
// companion with a registered copy of y and a saturating high-cycle counter.
module and2 #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             cnt_clr,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] hi_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             nand_s;
  logic             and_s;
  logic             y_d;
  logic             y_reg_q;
  logic [CNT_W-1:0] hi_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q;

  // Gate structure is NAND then inverter; no storage on this path.
  assign nand_s = ~(a & b);
  assign and_s  = ~nand_s;
  assign y      = and_s;

  // Next-state logic: clear beats increment, counter sticks at all-ones.
  always_comb begin
    y_d      = and_s;
    hi_cnt_d = hi_cnt_q;
    if (cnt_clr) begin
      hi_cnt_d = CNT_ZERO;
    end else if (and_s && (hi_cnt_q != CNT_MAX)) begin
      hi_cnt_d = hi_cnt_q + CNT_ONE;
    end else begin
      hi_cnt_d = hi_cnt_q;
    end
  end

  // State registers; reset clears immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg_q  <= 1'b0;
      hi_cnt_q <= CNT_ZERO;
    end else begin
      y_reg_q  <= y_d;
      hi_cnt_q <= hi_cnt_d;
    end
  end

  assign y_q    = y_reg_q;
  assign hi_cnt = hi_cnt_q;

endmodule

// File: tb/tb_and2.sv
// Randomized and directed self-checking bench for and2, comparing against a
// cycle-level reference model (integer counters with min() saturation).
module tb_and2;

  logic       clk;
  logic       clk_run;
  logic       rst_n;
  logic       a;
  logic       b;
  logic       cnt_clr;
  logic       y8;
  logic       yq8;
  logic [7:0] hi8;
  logic       y2;
  logic       yq2;
  logic [1:0] hi2;

  int total;
  int bad;

  // model state
  int yq_m;
  int cnt8_m;
  int cnt2_m;

  and2 #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cnt_clr(cnt_clr),
    .y(y8), .y_q(yq8), .hi_cnt(hi8)
  );

  and2 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cnt_clr(cnt_clr),
    .y(y2), .y_q(yq2), .hi_cnt(hi2)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (a=%b b=%b clr=%b rst_n=%b t=%0t)",
               tag, got, exp, a, b, cnt_clr, rst_n, $time);
    end
  endtask

  function automatic int sat_inc(input int v, input int width);
    int lim;
    lim = (1 << width) - 1;
    return (v + 1 > lim) ? lim : v + 1;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".y"},    32'(y8),  32'((a === 1'b1 && b === 1'b1) ? 1 : 0));
    check({tag, ".y2"},   32'(y2),  32'((a === 1'b1 && b === 1'b1) ? 1 : 0));
    check({tag, ".yq"},   32'(yq8), 32'(yq_m));
    check({tag, ".yq2"},  32'(yq2), 32'(yq_m));
    check({tag, ".cnt8"}, 32'(hi8), 32'(cnt8_m));
    check({tag, ".cnt2"}, 32'(hi2), 32'(cnt2_m));
  endtask

  // One rising edge: advance the model from the inputs present at the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    yq_m = (a && b) ? 1 : 0;
    if (cnt_clr) begin
      cnt8_m = 0;
      cnt2_m = 0;
    end else if (a && b) begin
      cnt8_m = sat_inc(cnt8_m, 8);
      cnt2_m = sat_inc(cnt2_m, 2);
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic ai, input logic bi, input logic ci);
    a = ai;
    b = bi;
    cnt_clr = ci;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    yq_m = 0;
    cnt8_m = 0;
    cnt2_m = 0;
    #1;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_sat[6];
    total = 0;
    bad = 0;
    clk = 1'b0;
    clk_run = 1'b0;
    rst_n = 1'b0;
    yq_m = 0;
    cnt8_m = 0;
    cnt2_m = 0;
    drive(1'b0, 1'b0, 1'b0);

    // truth table with the clock stopped and reset asserted
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      a = ab[1];
      b = ab[0];
      #10;
      check("tt.y", 32'(y8), 32'((i == 3) ? 1 : 0));
      check("tt.reset_state", {yq8, hi8}, 32'd0);
    end
    if (bad != 0) begin
      $display("FAIL truth_table: %0d errors, stopping", bad);
      $fatal(1, "truth table");
    end
    $display("truth table pass");

    // X handling on the combinational path
    a = 1'b0; b = 1'bx; #1;
    check("x.a0", 32'(y8), 32'd0);
    a = 1'b1; b = 1'bx; #1;
    check("x.a1", {31'd0, y8}, {31'd0, 1'bx});
    drive(1'b0, 1'b0, 1'b0);

    // start clock, release reset between edges
    clk_run = 1'b1;
    #7;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick("pre_rst");
    end
    check("pre_rst.yq", 32'(yq8), 32'd1);
    check("pre_rst.cnt", 32'(hi8), 32'd3);
    #2;
    do_reset();
    check("rst.y_tracks", 32'(y8), 32'd1);

    // registered latency: y falls at once, y_q at the next edge
    tick("lat0");
    drive(1'b0, 1'b1, 1'b0);
    #1;
    check("lat.y_now", 32'(y8), 32'd0);
    check("lat.yq_old", 32'(yq8), 32'd1);
    tick("lat1");
    check("lat.yq_new", 32'(yq8), 32'd0);

    // saturation of the 2-bit instance
    do_reset();
    exp_sat = '{1, 2, 3, 3, 3, 3};
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick("sat");
      check("sat.tab", 32'(hi2), 32'(exp_sat[k]));
    end

    // clear priority
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    tick("clr_a");
    tick("clr_b");
    check("clr.pre", 32'(hi8), 32'd2);
    drive(1'b1, 1'b1, 1'b1);
    tick("clr");
    check("clr.zero", 32'(hi8), 32'd0);
    drive(1'b1, 1'b1, 1'b0);
    tick("clr_after");
    check("clr.one", 32'(hi8), 32'd1);

    // drive the 8-bit counter into saturation
    for (int k = 0; k < 260; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick("sat8");
    end
    check("sat8.top", 32'(hi8), 32'd255);

    // randomized traffic with occasional clears and resets
    for (int k = 0; k < 600; k++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 99) == 0) begin
        #2;
        do_reset();
      end else begin
        tick("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
